difftest_commit_tracker: RTL

Parametrised commit tracker between the core's writeback/retire stage and the Difftest DPI modules (DifftestInstrCommit per lane, DifftestTrapEvent). It accepts up to NR_COMMIT retired instructions per cycle and registers them into per-lane commit records. It detects the trap instruction and freezes all reporting after it. It maintains cycle and instruction counters and runs a no-commit watchdog that raises a synthetic trap when the core hangs.

---
 rtl/difftest_commit_tracker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/difftest_commit_tracker.sv
// Registers retired lanes into Difftest commit records, detects the trap
// instruction, counts cycles/instructions and runs a no-commit watchdog.
module difftest_commit_tracker #(
    parameter int NR_COMMIT = 2,
    parameter int XLEN      = 64,
    parameter int TIMEOUT   = 5000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NR_COMMIT-1:0]      in_valid,
    input  logic [NR_COMMIT*XLEN-1:0] in_pc,
    input  logic [NR_COMMIT*32-1:0]   in_inst,
    input  logic [NR_COMMIT-1:0]      in_wen,
    input  logic [NR_COMMIT*5-1:0]    in_wdest,
    input  logic [NR_COMMIT*XLEN-1:0] in_wdata,
    input  logic [XLEN-1:0]           in_a0,
    output logic [NR_COMMIT-1:0]      cmt_valid,
    output logic [NR_COMMIT*XLEN-1:0] cmt_pc,
    output logic [NR_COMMIT*32-1:0]   cmt_inst,
    output logic [NR_COMMIT-1:0]      cmt_wen,
    output logic [NR_COMMIT*8-1:0]    cmt_wdest,
    output logic [NR_COMMIT*XLEN-1:0] cmt_wdata,
    output logic                      trap_valid,
    output logic [7:0]                trap_code,
    output logic [XLEN-1:0]           trap_pc,
    output logic                      timeout,
    output logic [63:0]               cycle_cnt,
    output logic [63:0]               instr_cnt
);

    localparam logic        WD_EN  = (TIMEOUT != 0);
    localparam logic [31:0] WD_MAX = 32'(TIMEOUT);
    localparam logic [31:0] WD_LIM = WD_EN ? 32'(TIMEOUT - 1) : 32'd0;

    logic [NR_COMMIT-1:0] fwd;
    logic [2:0]           fwd_n;
    logic                 hit;
    logic [XLEN-1:0]      hit_pc;
    logic [XLEN-1:0]      fwd_pc;
    logic                 open;
    logic                 wd_fire;
    logic [31:0]          idle_cnt;
    logic [XLEN-1:0]      last_pc;

    // Accept the contiguous valid prefix, stopping after the first trap lane.
    always_comb begin
        fwd    = '0;
        fwd_n  = 3'd0;
        hit    = 1'b0;
        hit_pc = '0;
        fwd_pc = last_pc;
        open   = 1'b1;
        for (int i = 0; i < NR_COMMIT; i++) begin
            if (open && in_valid[i]) begin
                fwd[i] = 1'b1;
                fwd_n  = fwd_n + 3'd1;
                fwd_pc = in_pc[i*XLEN +: XLEN];
                if (in_inst[i*32 +: 7] == 7'h6b) begin
                    hit    = 1'b1;
                    hit_pc = in_pc[i*XLEN +: XLEN];
                    open   = 1'b0;
                end
            end else begin
                open = 1'b0;
            end
        end
    end

    // Fires on the TIMEOUT-th cycle since the last forwarded lane.
    assign wd_fire = WD_EN && (idle_cnt >= WD_LIM);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cmt_valid  <= '0;
            cmt_pc     <= '0;
            cmt_inst   <= '0;
            cmt_wen    <= '0;
            cmt_wdest  <= '0;
            cmt_wdata  <= '0;
            trap_valid <= 1'b0;
            trap_code  <= 8'h00;
            trap_pc    <= '0;
            timeout    <= 1'b0;
            cycle_cnt  <= 64'd0;
            instr_cnt  <= 64'd0;
            idle_cnt   <= 32'd0;
            last_pc    <= '0;
        end else if (trap_valid) begin
            cmt_valid <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            instr_cnt <= instr_cnt + {61'd0, fwd_n};
            cmt_valid <= fwd;
            last_pc   <= fwd_pc;
            for (int i = 0; i < NR_COMMIT; i++) begin
                if (fwd[i]) begin
                    cmt_pc[i*XLEN +: XLEN]   <= in_pc[i*XLEN +: XLEN];
                    cmt_inst[i*32 +: 32]     <= in_inst[i*32 +: 32];
                    cmt_wen[i]               <= in_wen[i] &
                                                (in_wdest[i*5 +: 5] != 5'd0);
                    cmt_wdest[i*8 +: 8]      <= {3'd0, in_wdest[i*5 +: 5]};
                    cmt_wdata[i*XLEN +: XLEN] <= in_wdata[i*XLEN +: XLEN];
                end
            end
            if (fwd_n != 3'd0)
                idle_cnt <= 32'd0;
            else if (idle_cnt < WD_MAX)
                idle_cnt <= idle_cnt + 32'd1;
            if (hit) begin
                trap_valid <= 1'b1;
                trap_code  <= in_a0[7:0];
                trap_pc    <= hit_pc;
            end else if (wd_fire) begin
                trap_valid <= 1'b1;
                timeout    <= 1'b1;
                trap_code  <= 8'hFF;
                trap_pc    <= last_pc;
            end
        end
    end

endmodule
